multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control FSM for the RV32I datapath, replacing the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back over a shared instruction/data memory port with a ready handshake. It decodes R/I-type ALU ops, loads/stores, BEQ/BNE, JAL, JALR, LUI and AUIPC, and resolves branches internally. It detects illegal encodings and memory timeouts and enters a sticky fault state.

## Interface
- `MEM_TIMEOUT`, 16: max cycles a memory request may wait for `mem_ready` before fault (≥1).
- `ENABLE_MEM`, 1: when 0, load/store opcodes are illegal.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `opcode` in 7: from instruction register, stable from the cycle after `ir_write` until the next fetch.
- `funct3` in 3: from instruction register.
- `funct7` in 7: from instruction register.
- `zero` in 1: ALU zero flag, valid in EXEC.
- `mem_ready` in 1: memory completes current request this cycle.
- `mem_req` out 1: memory request active.
- `memwrite` out 1: request is a store (only with `mem_req`).
- `ir_write` out 1: latch instruction word.
- `pc_write` out 1: update PC this cycle.
- `pc_src` out 2: 00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result (JALR).
- `wb_sel` out 2: 00 ALU, 01 memory data, 10 PC+4.
- `mem2reg` out 1: equals (`wb_sel`==01).
- `alusrc` out 1: ALU B operand is immediate.
- `regwrite` out 1: register file write strobe.
- `aluctl` out 4: ALU operation.
- `branch_taken` out 1: branch/jump redirect this cycle.
- `fault` out 1: sticky fault indication.
- `state` out 3: current FSM state, for debug.

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- START: one cycle after reset, all strobes 0, then FETCH.
- FETCH: `mem_req`=1, `memwrite`=0. On `mem_ready`, `ir_write`=1 and go to DECODE.
- DECODE: checks legality. Illegal opcode, funct combination, or load/store with `ENABLE_MEM`=0 goes to FAULT. Otherwise go to EXEC.
- EXEC, ALU ops (R, I, LUI, AUIPC): drive `aluctl`/`alusrc`, then WB.
  - `alusrc`=1 for I, LUI, AUIPC, load, store, JALR.
- EXEC, load/store: `aluctl`=ADD, `alusrc`=1, then MEM.
- EXEC, BEQ/BNE: `aluctl`=SUB. `branch_taken` = `zero` for BEQ, !`zero` for BNE. `pc_write`=1, `pc_src`=01 if taken else 00, then FETCH.
- EXEC, JAL: `pc_src`=01. JALR: `pc_src`=10, `aluctl`=ADD. For both, `branch_taken`=1 and go to WB. The PC is updated in WB.
- MEM: `mem_req`=1, `memwrite`=store. On `mem_ready`, a load goes to WB; a store sets `pc_write`=1 (`pc_src` 00) and goes to FETCH.
- WB: `regwrite`=1 and `wb_sel` by class: ALU ops 00, load 01, JAL/JALR 10. `pc_write`=1 with `pc_src` 00, or the jump source latched in EXEC. Then FETCH.
- aluctl:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 0111.
  - funct3 000 → ADD, or SUB if R-type and funct7[5].
  - funct3 111/110/100/010 → AND/OR/XOR/SLT.
  - Any other funct3 for R/I is illegal. R-type funct7 other than 0x00/0x20 is illegal.
- Timeout: a counter increments each cycle `mem_req`=1 and !`mem_ready`. It clears on `mem_ready` or a state change. At count==`MEM_TIMEOUT`, go to FAULT.
- FAULT: all strobes 0, `fault`=1, held until `rst`.

## Timing
- Reset values: state=START; all outputs 0 except `state`; timeout counter 0. `rst` mid-instruction aborts immediately with no write-back.
- All strobes are Moore outputs, except `ir_write`, MEM-state `pc_write`, and `branch_taken` in EXEC, which depend combinationally on `mem_ready`/`zero`.
- Zero-wait latency: branch 3 cycles, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5. Each memory wait cycle adds 1.
- `mem_ready` asserted in the same cycle `mem_req` rises completes in that cycle.
- `mem_ready` outside FETCH/MEM is ignored.
- A timeout takes exactly `MEM_TIMEOUT` cycles of unanswered request and enters FAULT on the next edge. `mem_ready` on the final cycle wins over timeout.

## Structure
- Shared package `ctrl_pkg`: opcode constants, `aluctl` codes, state enum, `pc_src`/`wb_sel` encodings.
- Sub-module `alu_decoder`: combinational map from class/funct3/funct7 to `aluctl` plus illegal flag.
- FSM, timeout counter, and latched jump class live in the top module.

## Test plan
- ADD x3,x1,x2 (0110011/000/0000000), `mem_ready` tied 1 → `regwrite` in cycle 4, `aluctl`=0010, `wb_sel`=00.
- SUB (funct7=0x20) with 2 fetch wait cycles → `aluctl`=0110 in EXEC, `regwrite` in cycle 6.
- BEQ with `zero`=1 → EXEC `pc_write`=1, `pc_src`=01, `branch_taken`=1, no `regwrite`. With `zero`=0 → `pc_src`=00.
- LW then SW (`ENABLE_MEM`=1) → LW: MEM `memwrite`=0, WB `wb_sel`=01 at cycle 5. SW: MEM `memwrite`=1, no `regwrite`.
- JALR → WB `regwrite`=1, `wb_sel`=10, `pc_src`=10.
- Timeout and illegal decode:
  - `mem_ready` held 0 in FETCH, `MEM_TIMEOUT`=4 → `fault`=1 after 4 wait cycles and stays through later `mem_ready`.
  - Opcode 0000000 → FAULT from DECODE.
  - `rst` pulse → START, `fault`=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU
// control codes, PC/write-back source selects, FSM states, instruction classes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC+4
  localparam logic [1:0] PC_SRC_REL = 2'b01;  // PC+imm
  localparam logic [1:0] PC_SRC_ALU = 2'b10;  // ALU result

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_NONE
  } class_e;

  function automatic class_e classify(input logic [6:0] op);
    class_e c;
    case (op)
      OP_R:      c = CLS_R;
      OP_I:      c = CLS_I;
      OP_LOAD:   c = CLS_LOAD;
      OP_STORE:  c = CLS_STORE;
      OP_BRANCH: c = CLS_BRANCH;
      OP_JAL:    c = CLS_JAL;
      OP_JALR:   c = CLS_JALR;
      OP_LUI:    c = CLS_LUI;
      OP_AUIPC:  c = CLS_AUIPC;
      default:   c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from instruction class and funct fields to the ALU
// control code, flagging encodings that the datapath does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  class_e     cls_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] aluctl_o,
  output logic       illegal_o
);

  // ALU operation select and legality of the funct fields for each class
  always_comb begin
    aluctl_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_R, CLS_I: begin
        case (funct3_i)
          3'b000:  aluctl_o = (cls_i == CLS_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
          3'b111:  aluctl_o = ALU_AND;
          3'b110:  aluctl_o = ALU_OR;
          3'b100:  aluctl_o = ALU_XOR;
          3'b010:  aluctl_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
        if (cls_i == CLS_R && funct7_i != 7'h00 && funct7_i != 7'h20) begin
          illegal_o = 1'b1;
        end
      end
      CLS_BRANCH: begin
        aluctl_o = ALU_SUB;
        // only BEQ (000) and BNE (001) are implemented
        illegal_o = (funct3_i[2:1] != 2'b00);
      end
      CLS_LOAD: begin
        illegal_o = !(funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010 ||
                      funct3_i == 3'b100 || funct3_i == 3'b101);
      end
      CLS_STORE: begin
        illegal_o = !(funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010);
      end
      CLS_JALR: begin
        illegal_o = (funct3_i != 3'b000);
      end
      CLS_JAL, CLS_LUI, CLS_AUIPC: begin
        aluctl_o = ALU_ADD;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM sharing one memory port for fetch and data.
//
// state  | meaning
// START  | one idle cycle after reset
// FETCH  | instruction read; ir_write on mem_ready
// DECODE | legality check of the latched instruction
// EXEC   | ALU op / address calc / branch resolve / jump source select
// MEM    | data load or store; store retires here
// WB     | register write and PC update
// FAULT  | sticky error, left only through rst
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          ENABLE_MEM  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       mem2reg,
  output logic       alusrc,
  output logic       regwrite,
  output logic [3:0] aluctl,
  output logic       branch_taken,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned    CNT_W    = $clog2(MEM_TIMEOUT + 1);
  // last unanswered cycle that is still tolerated; one more wait means fault
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       jump_src_q, jump_src_d;

  class_e     cls;
  logic [3:0] dec_aluctl;
  logic       dec_illegal;
  logic       is_mem_op;
  logic       illegal;
  logic       taken;
  logic       tmo_hit;

  assign cls       = classify(opcode);
  assign is_mem_op = (cls == CLS_LOAD) || (cls == CLS_STORE);
  assign illegal   = dec_illegal || (is_mem_op && !ENABLE_MEM);
  // funct3[0] distinguishes BNE from BEQ
  assign taken     = funct3[0] ? !zero : zero;
  assign tmo_hit   = (tmo_cnt_q == CNT_LAST);

  alu_decoder u_alu_decoder (
    .cls_i     (cls),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .aluctl_o  (dec_aluctl),
    .illegal_o (dec_illegal)
  );

  // Next state and all control strobes
  always_comb begin
    state_d      = state_q;
    jump_src_d   = jump_src_q;
    mem_req      = 1'b0;
    memwrite     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    wb_sel       = WB_ALU;
    alusrc       = 1'b0;
    regwrite     = 1'b0;
    aluctl       = ALU_AND;
    branch_taken = 1'b0;
    fault        = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = illegal ? ST_FAULT : ST_EXEC;
      ST_EXEC: begin
        aluctl     = dec_aluctl;
        alusrc     = (cls != CLS_R) && (cls != CLS_BRANCH) && (cls != CLS_JAL);
        jump_src_d = PC_SRC_SEQ;
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            branch_taken = taken;
            pc_write     = 1'b1;
            pc_src       = taken ? PC_SRC_REL : PC_SRC_SEQ;
            state_d      = ST_FETCH;
          end
          CLS_JAL: begin
            pc_src       = PC_SRC_REL;
            jump_src_d   = PC_SRC_REL;
            branch_taken = 1'b1;
            state_d      = ST_WB;
          end
          CLS_JALR: begin
            pc_src       = PC_SRC_ALU;
            jump_src_d   = PC_SRC_ALU;
            branch_taken = 1'b1;
            state_d      = ST_WB;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        memwrite = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        regwrite = 1'b1;
        pc_write = 1'b1;
        pc_src   = jump_src_q;
        case (cls)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          default:           wb_sel = WB_ALU;
        endcase
        state_d = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Wait counter: counts unanswered request cycles within one memory state
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready && state_d == state_q) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  assign mem2reg = (wb_sel == WB_MEM);
  assign state   = state_q;

  // State, wait counter and latched jump source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      tmo_cnt_q  <= '0;
      jump_src_q <= PC_SRC_SEQ;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      jump_src_q <= jump_src_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4) plus a second
// instance with memory ops disabled.
module tb_multicycle_control_unit;

  localparam logic [2:0] S_START = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       memwrite;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic       mem2reg;
    logic       alusrc;
    logic       regwrite;
    logic [3:0] aluctl;
    logic       taken;
    logic       fault;
  } obs_t;

  logic       clk, rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, ir_write, pc_write, mem2reg, alusrc, regwrite, branch_taken, fault;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] aluctl;
  logic [2:0] state;

  logic       nm_mem_req, nm_memwrite, nm_ir_write, nm_pc_write, nm_mem2reg, nm_alusrc;
  logic       nm_regwrite, nm_branch_taken, nm_fault;
  logic [1:0] nm_pc_src, nm_wb_sel;
  logic [3:0] nm_aluctl;
  logic [2:0] nm_state;

  obs_t obs;
  int   n_cmp = 0;
  int   n_err = 0;

  assign obs = {state, mem_req, memwrite, ir_write, pc_write, pc_src, wb_sel, mem2reg,
                alusrc, regwrite, aluctl, branch_taken, fault};

  multicycle_control_unit #(.MEM_TIMEOUT(4), .ENABLE_MEM(1'b1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .wb_sel(wb_sel), .mem2reg(mem2reg), .alusrc(alusrc),
    .regwrite(regwrite), .aluctl(aluctl), .branch_taken(branch_taken), .fault(fault),
    .state(state)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4), .ENABLE_MEM(1'b0)) u_dut_nomem (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(nm_mem_req), .memwrite(nm_memwrite),
    .ir_write(nm_ir_write), .pc_write(nm_pc_write), .pc_src(nm_pc_src), .wb_sel(nm_wb_sel),
    .mem2reg(nm_mem2reg), .alusrc(nm_alusrc), .regwrite(nm_regwrite), .aluctl(nm_aluctl),
    .branch_taken(nm_branch_taken), .fault(nm_fault), .state(nm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse reset and leave the DUT in its first FETCH cycle
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    e = '0; e.st = S_START;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1; #1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_start got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL reset_fetch got=%h exp=%h", obs, e); end
  endtask

  task automatic test_add();
    obs_t e;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00; mem_ready = 1'b1;
    #1;
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL add_c1 got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_DECODE;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL add_c2 got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0010;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL add_c3 got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1; e.wb_sel = 2'b00;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL add_c4 got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL add_c5 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_sub_wait();
    obs_t e;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h20; mem_ready = 1'b0;
    #1;
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sub_c1 got=%h exp=%h", obs, e); end
    tick();
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sub_c2 got=%h exp=%h", obs, e); end
    tick();
    mem_ready = 1'b1; #1;
    e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sub_c3 got=%h exp=%h", obs, e); end
    tick();
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0110;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sub_c5 got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sub_c6 got=%h exp=%h", obs, e); end
    tick();
  endtask

  task automatic test_alu_table();
    typedef struct packed {
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [3:0] alu; logic src;
    } vec_t;
    vec_t vecs [6];
    obs_t e;
    vecs[0] = '{7'b0110011, 3'b111, 7'h00, 4'b0000, 1'b0};  // AND
    vecs[1] = '{7'b0110011, 3'b110, 7'h00, 4'b0001, 1'b0};  // OR
    vecs[2] = '{7'b0110011, 3'b100, 7'h00, 4'b0011, 1'b0};  // XOR
    vecs[3] = '{7'b0010011, 3'b010, 7'h7f, 4'b0111, 1'b1};  // SLTI
    vecs[4] = '{7'b0010011, 3'b000, 7'h20, 4'b0010, 1'b1};  // ADDI, funct7 bits are imm
    vecs[5] = '{7'b0010011, 3'b110, 7'h00, 4'b0001, 1'b1};  // ORI
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = vecs[i].op; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      tick();
      tick();
      e = '0; e.st = S_EXEC; e.aluctl = vecs[i].alu; e.alusrc = vecs[i].src;
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL alu_exec[%0d] got=%h exp=%h", i, obs, e); end
      tick();
      e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1;
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL alu_wb[%0d] got=%h exp=%h", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_taken);
    obs_t e;
    opcode = 7'b1100011; funct3 = f3; funct7 = 7'h00; mem_ready = 1'b1; zero = z;
    tick();
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0110; e.pc_write = 1'b1;
    e.taken = exp_taken; e.pc_src = exp_taken ? 2'b01 : 2'b00;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL br_exec f3=%0d z=%0d got=%h exp=%h", f3, z, obs, e); end
    zero = ~z; #1;
    e.taken = ~exp_taken; e.pc_src = exp_taken ? 2'b00 : 2'b01;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL br_flip f3=%0d z=%0d got=%h exp=%h", f3, z, obs, e); end
    tick();
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL br_next f3=%0d z=%0d got=%h exp=%h", f3, z, obs, e); end
    zero = 1'b0;
  endtask

  task automatic test_load_store();
    obs_t e;
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00; mem_ready = 1'b1;
    tick();
    n_cmp++; if (nm_state !== S_DECODE) begin n_err++; $display("FAIL nomem_decode got=%0d exp=%0d", nm_state, S_DECODE); end
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0010; e.alusrc = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL lw_exec got=%h exp=%h", obs, e); end
    n_cmp++; if (nm_fault !== 1'b1) begin n_err++; $display("FAIL nomem_fault got=%0b exp=1", nm_fault); end
    tick();
    e = '0; e.st = S_MEM; e.mem_req = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL lw_mem got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1; e.wb_sel = 2'b01; e.mem2reg = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL lw_wb got=%h exp=%h", obs, e); end
    tick();
    opcode = 7'b0100011; funct3 = 3'b010;
    tick();
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0010; e.alusrc = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sw_exec got=%h exp=%h", obs, e); end
    mem_ready = 1'b0;
    tick();
    e = '0; e.st = S_MEM; e.mem_req = 1'b1; e.memwrite = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sw_mem_wait got=%h exp=%h", obs, e); end
    tick();
    mem_ready = 1'b1; #1;
    e.pc_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sw_mem_done got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL sw_next got=%h exp=%h", obs, e); end
  endtask

  task automatic test_jumps();
    obs_t e, m;
    opcode = 7'b1100111; funct3 = 3'b000; mem_ready = 1'b1;
    tick();
    tick();
    e = '0; e.st = S_EXEC; e.pc_src = 2'b10; e.aluctl = 4'b0010; e.alusrc = 1'b1; e.taken = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL jalr_exec got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; e.wb_sel = 2'b10;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL jalr_wb got=%h exp=%h", obs, e); end
    tick();
    opcode = 7'b1101111;
    tick();
    tick();
    m = obs; m.aluctl = '0;
    e = '0; e.st = S_EXEC; e.pc_src = 2'b01; e.taken = 1'b1;
    n_cmp++; if (m !== e) begin n_err++; $display("FAIL jal_exec got=%h exp=%h", m, e); end
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b01; e.wb_sel = 2'b10;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL jal_wb got=%h exp=%h", obs, e); end
    tick();
  endtask

  task automatic test_timeout();
    obs_t e;
    do_reset();
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00; mem_ready = 1'b0;
    #1;
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL tmo_wait[%0d] got=%h exp=%h", c, obs, e); end
      tick();
    end
    e = '0; e.st = S_FAULT; e.fault = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL tmo_fault got=%h exp=%h", obs, e); end
    mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL tmo_sticky got=%h exp=%h", obs, e); end
  endtask

  task automatic test_timeout_edge();
    obs_t e;
    do_reset();
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00; mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1; #1;
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL edge_fetch got=%h exp=%h", obs, e); end
    tick();
    tick();
    mem_ready = 1'b0;
    repeat (4) tick();
    e = '0; e.st = S_MEM; e.mem_req = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL edge_mem_wait got=%h exp=%h", obs, e); end
    mem_ready = 1'b1;
    tick();
    e = '0; e.st = S_WB; e.regwrite = 1'b1; e.pc_write = 1'b1; e.wb_sel = 2'b01; e.mem2reg = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL edge_wb got=%h exp=%h", obs, e); end
    tick();
  endtask

  task automatic test_illegal();
    obs_t e;
    do_reset();
    opcode = 7'b0000000; funct3 = 3'b000; funct7 = 7'h00; mem_ready = 1'b1;
    tick();
    e = '0; e.st = S_DECODE;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ill_decode got=%h exp=%h", obs, e); end
    tick();
    e = '0; e.st = S_FAULT; e.fault = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ill_op got=%h exp=%h", obs, e); end
    #2 rst = 1'b1; #1;
    e = '0; e.st = S_START;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ill_async_rst got=%h exp=%h", obs, e); end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    opcode = 7'b0110011; funct7 = 7'h01;
    tick();
    tick();
    e = '0; e.st = S_FAULT; e.fault = 1'b1;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ill_funct7 got=%h exp=%h", obs, e); end
    do_reset();
    opcode = 7'b0010011; funct3 = 3'b001; funct7 = 7'h00; mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL ill_funct3 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    do_reset();
    opcode = 7'b0110011; funct3 = 3'b100; funct7 = 7'h00; mem_ready = 1'b1;
    repeat (4) tick();
    opcode = 7'b0110011; funct3 = 3'b111;
    tick();
    tick();
    e = '0; e.st = S_EXEC; e.aluctl = 4'b0000;
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL b2b_exec got=%h exp=%h", obs, e); end
    n_cmp++; if (nm_state !== S_EXEC) begin n_err++; $display("FAIL b2b_nomem got=%0d exp=%0d", nm_state, S_EXEC); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wait();
    test_alu_table();
    test_branch(3'b000, 1'b1, 1'b1);
    test_branch(3'b000, 1'b0, 1'b0);
    test_branch(3'b001, 1'b0, 1'b1);
    test_load_store();
    test_jumps();
    test_timeout();
    test_timeout_edge();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
